// File: rtl/mac_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mac_seq_ctrl                                                 |
// | Description : Sequences NGROUPS pixel/weight groups into an external MAC   |
// |               and accumulates the returned partial sums into a saturating  |
// |               signed neuron accumulator.                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk       in   rising-edge clock                                         |
// |   rst       in   asynchronous active-high reset                            |
// |   start     in   begin one neuron accumulation (honoured in IDLE only)     |
// |   in_valid  in   pix_in/w_in hold a valid group                            |
// |   in_ready  out  a group is accepted this cycle when in_valid is high      |
// |   pix_in    in   LANES spike pixels, bit i pairs with weight lane i        |
// |   w_in      in   LANES weights, lane i at [WIDTH*i +: WIDTH]               |
// |   mac_p     out  registered pixels presented to the MAC                    |
// |   mac_w     out  registered weights presented to the MAC                   |
// |   mac_sum   in   signed MAC result, valid MAC_LAT cycles after mac_p/mac_w |
// |   acc_out   out  signed accumulated neuron sum (7 fractional bits)         |
// |   out_valid out  one-cycle pulse, acc_out is final                         |
// |   busy      out  controller is not IDLE                                    |
// +----------------------------------------------------------------------------+
module mac_seq_ctrl #(
  parameter int WIDTH   = 8,
  parameter int LANES   = 5,
  parameter int NGROUPS = 4,
  parameter int MAC_LAT = 1,
  parameter int ACC_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        pix_in,
  input  logic [WIDTH*LANES-1:0]  w_in,
  output logic [LANES-1:0]        mac_p,
  output logic [WIDTH*LANES-1:0]  mac_w,
  input  logic signed [WIDTH+2:0] mac_sum,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    out_valid,
  output logic                    busy
);

  localparam int CW = $clog2(NGROUPS + 1);
  localparam int c_ext_bits = ACC_W + 1 - (WIDTH + 3);
  localparam logic [CW-1:0]    c_grp_last = CW'(NGROUPS - 1);
  localparam logic [ACC_W-1:0] c_acc_max  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] c_acc_min  = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [CW-1:0]            r_grp;
  logic [CW-1:0]            r_outstanding;
  logic [MAC_LAT:0]         r_tag;
  logic signed [ACC_W-1:0]  r_acc;
  logic [LANES-1:0]         r_mac_p;
  logic [WIDTH*LANES-1:0]   r_mac_w;

  logic                     w_xfer;
  logic                     w_last_xfer;
  logic                     w_acc_en;
  logic                     w_start_ok;
  logic [ACC_W:0]           w_sum_wide;
  logic [ACC_W-1:0]         w_acc_nxt;

  assign w_xfer      = in_valid & in_ready;
  assign w_last_xfer = w_xfer && (r_grp == c_grp_last);
  // The oldest tag stage lines up with the cycle in which mac_sum belongs
  // to the group issued MAC_LAT+1 cycles earlier.
  assign w_acc_en    = r_tag[MAC_LAT];
  assign w_start_ok  = (r_state == IDLE) && start;

  assign mac_p   = r_mac_p;
  assign mac_w   = r_mac_w;
  assign acc_out = r_acc;

  // One guard bit above the accumulator: if it disagrees with the old sign
  // bit the true sum left the representable range and is clamped.
  assign w_sum_wide = {r_acc[ACC_W-1], r_acc}
                    + {{c_ext_bits{mac_sum[WIDTH+2]}}, mac_sum};

  always_comb begin
    w_acc_nxt = w_sum_wide[ACC_W-1:0];
    if (w_sum_wide[ACC_W] != w_sum_wide[ACC_W-1]) begin
      w_acc_nxt = w_sum_wide[ACC_W] ? c_acc_min : c_acc_max;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and control outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = FEED;
      end
      FEED: begin
        in_ready = 1'b1;
        if (w_last_xfer) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        // Counter reaching zero means the final add has already landed.
        if (r_outstanding == '0) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: MAC operand registers, issue tags, counters, accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mac_p       <= '0;
      r_mac_w       <= '0;
      r_tag         <= '0;
      r_grp         <= '0;
      r_outstanding <= '0;
      r_acc         <= '0;
    end else begin
      if (w_xfer) begin
        r_mac_p <= pix_in;
        r_mac_w <= w_in;
      end

      r_tag[0] <= w_xfer;
      for (int i = 1; i <= MAC_LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end

      if (w_start_ok) begin
        r_grp <= '0;
      end else if (w_xfer) begin
        r_grp <= r_grp + CW'(1);
      end

      if (w_start_ok) begin
        r_outstanding <= '0;
      end else if (w_xfer && !w_acc_en) begin
        r_outstanding <= r_outstanding + CW'(1);
      end else if (!w_xfer && w_acc_en) begin
        r_outstanding <= r_outstanding - CW'(1);
      end

      if (w_start_ok) begin
        r_acc <= '0;
      end else if (w_acc_en) begin
        r_acc <= w_acc_nxt;
      end
    end
  end

endmodule
`default_nettype wire
